// File: rtl/hamming_transmitter.sv
// hamming_transmitter: Hamming(7,4) encoder and serialiser for the serial Hamming link.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   d_in       data nibble [1:4], sampled when send is accepted
//   send       frame start request, accepted only while busy=0
//   err_pos    0 = clean frame, 1..7 = invert that codeword bit before sending
//   data_line  serial data, c1 first, held for a whole bit slot
//   strobe     one-cycle qualifier in the last cycle of each bit slot
//   busy       frame in progress (shift or gap)
//   done       one-cycle pulse at frame completion
//   code_out   codeword latched at send, including any injected error
//
// All outputs are flops, loaded from the next-state values, so nothing
// combinational reaches an output from an input.

module hamming_transmitter #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:4] d_in,
  input  logic       send,
  input  logic [2:0] err_pos,
  output logic       data_line,
  output logic       strobe,
  output logic       busy,
  output logic       done,
  output logic [1:7] code_out
);

  // One shared counter covers the bit slot (0..BIT_CYCLES-1) and the gap (0..GAP_CYCLES-1).
  localparam int unsigned MaxCnt = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] BitLast = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:7]      code_q, code_d;
  logic [1:7]      cw;
  logic            data_line_d, strobe_d, busy_d, done_d;

  // Encoder plus optional single-bit error injection.
  always_comb begin
    cw    = '0;
    cw[3] = d_in[1];
    cw[5] = d_in[2];
    cw[6] = d_in[3];
    cw[7] = d_in[4];
    cw[1] = cw[3] ^ cw[5] ^ cw[7];
    cw[2] = cw[3] ^ cw[6] ^ cw[7];
    cw[4] = cw[5] ^ cw[6] ^ cw[7];
    for (int i = 1; i <= 7; i++) begin
      if (err_pos == 3'(i)) cw[i] = ~cw[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      StIdle, StDone: begin
        // DONE accepts send exactly like IDLE so back-to-back frames lose no cycle.
        if (send) begin
          state_d = StShift;
          idx_d   = 3'd1;
          cnt_d   = '0;
          code_d  = cw;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = (GAP_CYCLES == 0) ? StDone : StGap;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Output flops are loaded from the next state so they line up with it.
    busy_d      = (state_d == StShift) || (state_d == StGap);
    done_d      = (state_d == StDone);
    strobe_d    = (state_d == StShift) && (cnt_d == BitLast);
    data_line_d = (state_d == StShift) ? code_d[idx_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      data_line <= 1'b0;
      strobe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      data_line <= data_line_d;
      strobe    <= strobe_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign code_out = code_q;

endmodule
